// File: rtl/fft_slave_iter.sv
// fft_slave_iter
// ---------------------------------------------------------------------------
// Iterative radix-2 decimation-in-time FFT bus slave. It collects N complex
// samples, transforms them in place with one time-shared butterfly, and
// returns N complex bins in natural order.
//
// Bus handshake (sel/ack):
//   The master raises sel and holds it for the whole transaction. The first
//   sel edge in IDLE and the next N-1 edges each capture one s_data_in word.
//   No back-pressure exists on either side. Every cycle ack is high,
//   s_data_out carries one valid bin, bins 0..N-1 in order. When ack is low,
//   s_data_out is forced to zero. Dropping sel before the last bin abandons
//   the transaction on the next edge. After the last bin the block parks in
//   DONE until sel goes low for at least one cycle.
//
// Parameters:
//   LOG2N  log2 of the point count (3 -> 8 points, 4 -> 16 points)
//   DW     width of each real/imag component (12..24)
//   SCALE  1 = arithmetic shift right by one after every stage
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   sel         slave select, held high for a transaction
//   inv         1 = inverse transform, sampled on the first sel edge
//   s_data_in   sample word {re, im}, signed components
//   ack         registered result-valid
//   s_data_out  registered result word {re, im}
//   busy        high from the first captured sample until DONE
//   state_dbg   current FSM state (IDLE=0 LOAD=1 CALC=2 OUT=3 DONE=4)
// ---------------------------------------------------------------------------
module fft_slave_iter #(
  parameter int LOG2N = 3,
  parameter int DW    = 16,
  parameter int SCALE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            inv,
  input  logic [2*DW-1:0] s_data_in,
  output logic            ack,
  output logic [2*DW-1:0] s_data_out,
  output logic            busy,
  output logic [2:0]      state_dbg
);

  localparam int N  = 1 << LOG2N;
  // Product width: DW-bit sample times 18-bit twiddle, plus one bit for the
  // sum of two products.
  localparam int PW = DW + 19;

  localparam logic [LOG2N-1:0] LAST_IDX   = '1;
  localparam logic [LOG2N-1:0] LAST_BFLY  = {1'b0, {(LOG2N-1){1'b1}}};
  localparam logic [LOG2N-1:0] ONE_IDX    = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  // cnt is the sample index in LOAD, the butterfly index j in CALC and the
  // output bin index in OUT.
  logic [LOG2N-1:0] cnt;
  logic [2:0]       stage;
  logic             inv_r;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  // Butterfly datapath signals
  logic [LOG2N-1:0]     lo_mask;
  logic [LOG2N-1:0]     p_addr;
  logic [LOG2N-1:0]     q_addr;
  logic [2:0]           tw_idx;
  logic signed [17:0]   wr;
  logic signed [17:0]   wi;
  logic signed [17:0]   sin_v;
  logic signed [DW-1:0] xr;
  logic signed [DW-1:0] xi;
  logic signed [DW-1:0] yr;
  logic signed [DW-1:0] yi;
  logic signed [PW-1:0] yr_e;
  logic signed [PW-1:0] yi_e;
  logic signed [PW-1:0] wr_e;
  logic signed [PW-1:0] wi_e;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pi;
  logic signed [DW-1:0] tr;
  logic signed [DW-1:0] ti;
  logic signed [DW-1:0] sum_r;
  logic signed [DW-1:0] sum_i;
  logic signed [DW-1:0] dif_r;
  logic signed [DW-1:0] dif_i;
  logic signed [DW-1:0] ar;
  logic signed [DW-1:0] ai;
  logic signed [DW-1:0] br;
  logic signed [DW-1:0] bi;

  // Bit-reversed load address so the in-place DIT passes yield natural order.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Q2.16 twiddle table for 16 points; 8 points uses the even entries.
  function automatic logic signed [17:0] tw_cos(input logic [2:0] i);
    case (i)
      3'd0:    return 18'sd65536;
      3'd1:    return 18'sd60547;
      3'd2:    return 18'sd46341;
      3'd3:    return 18'sd25080;
      3'd4:    return 18'sd0;
      3'd5:    return -18'sd25080;
      3'd6:    return -18'sd46341;
      default: return -18'sd60547;
    endcase
  endfunction

  function automatic logic signed [17:0] tw_sin(input logic [2:0] i);
    case (i)
      3'd0:    return 18'sd0;
      3'd1:    return 18'sd25080;
      3'd2:    return 18'sd46341;
      3'd3:    return 18'sd60547;
      3'd4:    return 18'sd65536;
      3'd5:    return 18'sd60547;
      3'd6:    return 18'sd46341;
      default: return 18'sd25080;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (sel) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (!sel)                 state_nx = S_IDLE;
        else if (cnt == LAST_IDX) state_nx = S_CALC;
      end
      S_CALC: begin
        if (!sel) state_nx = S_IDLE;
        else if (cnt == LAST_BFLY && stage == LAST_STAGE) state_nx = S_OUT;
      end
      S_OUT: begin
        if (!sel)                 state_nx = S_IDLE;
        else if (cnt == LAST_IDX) state_nx = S_DONE;
      end
      S_DONE: begin
        if (!sel) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      stage      <= '0;
      inv_r      <= 1'b0;
      ack        <= 1'b0;
      s_data_out <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      ack        <= 1'b0;
      s_data_out <= '0;
      busy       <= (state_nx == S_LOAD) || (state_nx == S_CALC) ||
                    (state_nx == S_OUT);
      case (state)
        S_IDLE: begin
          if (sel) begin
            inv_r <= inv;
            cnt   <= ONE_IDX;
          end
        end
        S_LOAD: begin
          // Wraps to zero after the last sample, ready for butterfly 0.
          cnt   <= cnt + 1'b1;
          stage <= '0;
        end
        S_CALC: begin
          if (cnt == LAST_BFLY) begin
            cnt   <= '0;
            stage <= stage + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          // Gated by sel so an abort clears the outputs on the same edge.
          ack        <= sel;
          s_data_out <= sel ? {mem_re[cnt], mem_im[cnt]} : '0;
          cnt        <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Butterfly addressing. p keeps the low s bits of j, inserts a zero at bit
  // s and shifts the rest up; q is p with bit s set (q = p + h).
  // The 16-point twiddle index is (j mod h) << (3 - s) for either size.
  // -------------------------------------------------------------------------
  always_comb begin
    lo_mask = ~({LOG2N{1'b1}} << stage);
    p_addr  = ((cnt & ~lo_mask) << 1) | (cnt & lo_mask);
    q_addr  = p_addr | (ONE_IDX << stage);
    tw_idx  = 3'({3'b000, cnt & lo_mask} << (3'd3 - stage));
  end

  // -------------------------------------------------------------------------
  // Butterfly arithmetic: t = y * W (full precision, floor >>> 16), then
  // a = x + t, b = x - t wrapped to DW bits, optionally halved.
  // -------------------------------------------------------------------------
  always_comb begin
    xr    = mem_re[p_addr];
    xi    = mem_im[p_addr];
    yr    = mem_re[q_addr];
    yi    = mem_im[q_addr];
    wr    = tw_cos(tw_idx);
    sin_v = tw_sin(tw_idx);
    // Forward uses cos - j*sin, inverse uses cos + j*sin.
    wi    = inv_r ? sin_v : -sin_v;

    yr_e  = PW'(yr);
    yi_e  = PW'(yi);
    wr_e  = PW'(wr);
    wi_e  = PW'(wi);
    pr    = yr_e * wr_e - yi_e * wi_e;
    pi    = yr_e * wi_e + yi_e * wr_e;
    tr    = DW'(pr >>> 16);
    ti    = DW'(pi >>> 16);

    sum_r = xr + tr;
    sum_i = xi + ti;
    dif_r = xr - tr;
    dif_i = xi - ti;

    if (SCALE != 0) begin
      ar = sum_r >>> 1;
      ai = sum_i >>> 1;
      br = dif_r >>> 1;
      bi = dif_i >>> 1;
    end else begin
      ar = sum_r;
      ai = sum_i;
      br = dif_r;
      bi = dif_i;
    end
  end

  // -------------------------------------------------------------------------
  // Sample memory: register file, two combinational reads, two writes per
  // cycle. Contents are not reset; every transaction rewrites all N entries
  // before they are read.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && sel) begin
      case (state)
        S_IDLE: begin
          mem_re[0] <= s_data_in[2*DW-1:DW];
          mem_im[0] <= s_data_in[DW-1:0];
        end
        S_LOAD: begin
          mem_re[bitrev(cnt)] <= s_data_in[2*DW-1:DW];
          mem_im[bitrev(cnt)] <= s_data_in[DW-1:0];
        end
        S_CALC: begin
          mem_re[p_addr] <= ar;
          mem_im[p_addr] <= ai;
          mem_re[q_addr] <= br;
          mem_im[q_addr] <= bi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_slave_iter.sv
// tb_fft_slave_iter
// Three instances share clk/rst: u0 = 8-point unscaled, u1 = 8-point scaled,
// u2 = 16-point unscaled. Expected bins come from directed constants or from
// a direct floating-point DFT of the stimulus vector.
module tb_fft_slave_iter;

  localparam real PI = 3.14159265358979;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel_a  [3];
  logic        inv_a  [3];
  logic [31:0] din_a  [3];
  logic [31:0] dout_a [3];
  logic        ack_a  [3];
  logic        busy_a [3];
  logic [2:0]  st_a   [3];

  fft_slave_iter #(.LOG2N(3), .DW(16), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .sel(sel_a[0]), .inv(inv_a[0]),
    .s_data_in(din_a[0]), .ack(ack_a[0]), .s_data_out(dout_a[0]),
    .busy(busy_a[0]), .state_dbg(st_a[0]));

  fft_slave_iter #(.LOG2N(3), .DW(16), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .sel(sel_a[1]), .inv(inv_a[1]),
    .s_data_in(din_a[1]), .ack(ack_a[1]), .s_data_out(dout_a[1]),
    .busy(busy_a[1]), .state_dbg(st_a[1]));

  fft_slave_iter #(.LOG2N(4), .DW(16), .SCALE(0)) u2 (
    .clk(clk), .rst(rst), .sel(sel_a[2]), .inv(inv_a[2]),
    .s_data_in(din_a[2]), .ack(ack_a[2]), .s_data_out(dout_a[2]),
    .busy(busy_a[2]), .state_dbg(st_a[2]));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] vin  [16];
  logic [31:0] vout [16];
  logic [31:0] orig [16];
  logic [31:0] exp_q [$];
  real ref_re [16];
  real ref_im [16];

  function automatic int npts(input int u);
    return (u == 2) ? 16 : 8;
  endfunction

  function automatic int ncalc(input int u);
    return (u == 2) ? 32 : 12;
  endfunction

  function automatic logic [31:0] pk(input int r, input int i);
    return {r[15:0], i[15:0]};
  endfunction

  function automatic int re_of(input logic [31:0] w);
    logic signed [15:0] t;
    t = w[31:16];
    return t;
  endfunction

  function automatic int im_of(input logic [31:0] w);
    logic signed [15:0] t;
    t = w[15:0];
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input real expv, input int tol);
    logic ok;
    real d;
    d  = real'(obs) - expv;
    ok = (d <= real'(tol)) && (d >= -real'(tol));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.2f tol=%0d", tag, obs, expv, tol);
    end
  endtask

  // Direct DFT of vin[0..n-1]; inverse includes the 1/n factor.
  task automatic dft(input int n, input bit inverse);
    real sr, si, ang, xr, xi;
    for (int k = 0; k < n; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int m = 0; m < n; m++) begin
        xr  = real'(re_of(vin[m]));
        xi  = real'(im_of(vin[m]));
        ang = 2.0 * PI * real'(k * m) / real'(n);
        if (!inverse) ang = -ang;
        sr += xr * $cos(ang) - xi * $sin(ang);
        si += xr * $sin(ang) + xi * $cos(ang);
      end
      if (inverse) begin
        sr = sr / real'(n);
        si = si / real'(n);
      end
      ref_re[k] = sr;
      ref_im[k] = si;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vin();
    for (int i = 0; i < 16; i++) vin[i] = '0;
  endtask

  task automatic rand_vin(input int n, input int amp);
    for (int i = 0; i < n; i++)
      vin[i] = pk($urandom_range(0, 2 * amp) - amp, $urandom_range(0, 2 * amp) - amp);
  endtask

  // Drives all N samples; returns just after the edge capturing sample N-1.
  // inv is flipped after cycle 0 and the data bus is scrambled afterwards.
  task automatic load(input int u, input logic inv_v);
    int n;
    n = npts(u);
    sel_a[u] = 1'b1;
    inv_a[u] = inv_v;
    din_a[u] = vin[0];
    for (int i = 1; i < n; i++) begin
      tick();
      if (i == 1) chk($sformatf("u%0d busy after first capture", u), {31'b0, busy_a[u]}, 32'd1);
      din_a[u] = vin[i];
      inv_a[u] = ~inv_v;
    end
    tick();
    din_a[u] = $urandom;
  endtask

  // Returns the edge index (edge 0 = first sel edge) after which ack is
  // first seen high, or -1 if it never rises within the budget.
  task automatic wait_ack(input int u, output int lat);
    int n;
    n   = npts(u);
    lat = -1;
    for (int e = n; e < n + 300; e++) begin
      tick();
      if (ack_a[u] === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  // Called with the first bin on the bus; captures all bins and checks the
  // ack window closes after exactly N cycles.
  task automatic collect(input int u, input string tag);
    int n;
    n = npts(u);
    vout[0] = dout_a[u];
    for (int k = 1; k < n; k++) begin
      tick();
      chk($sformatf("%s ack bin%0d", tag, k), {31'b0, ack_a[u]}, 32'd1);
      vout[k] = dout_a[u];
    end
    tick();
    chk($sformatf("%s ack drop", tag), {31'b0, ack_a[u]}, 32'd0);
    chk($sformatf("%s dout zero after", tag), dout_a[u], 32'd0);
  endtask

  task automatic run(input int u, input logic inv_v, input string tag);
    int lat;
    load(u, inv_v);
    wait_ack(u, lat);
    chk($sformatf("%s first ack latency", tag), lat, npts(u) + ncalc(u));
    collect(u, tag);
  endtask

  task automatic end_x(input int u);
    sel_a[u] = 1'b0;
    tick();
    chk($sformatf("u%0d idle after sel low", u), {29'b0, st_a[u]}, {29'b0, ST_IDLE});
  endtask

  // Compares vout against the exact words queued in exp_q.
  task automatic drain_exact(input int n, input string tag);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s bin%0d", tag, k), vout[k], e);
    end
  endtask

  task automatic cmp_ref(input int n, input int tol, input string tag);
    for (int k = 0; k < n; k++) begin
      chk_tol($sformatf("%s re%0d", tag, k), re_of(vout[k]), ref_re[k], tol);
      chk_tol($sformatf("%s im%0d", tag, k), im_of(vout[k]), ref_im[k], tol);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int ack_seen;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      sel_a[u] = 1'b0;
      inv_a[u] = 1'b0;
      din_a[u] = '0;
    end
    clear_vin();
    repeat (3) tick();

    // Reset values
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d reset ack", u),   {31'b0, ack_a[u]},  32'd0);
      chk($sformatf("u%0d reset dout", u),  dout_a[u],          32'd0);
      chk($sformatf("u%0d reset busy", u),  {31'b0, busy_a[u]}, 32'd0);
      chk($sformatf("u%0d reset state", u), {29'b0, st_a[u]},   {29'b0, ST_IDLE});
    end
    rst = 1'b0;
    tick();

    // Impulse -> flat spectrum
    clear_vin();
    vin[0] = pk(32'h1000, 0);
    run(0, 1'b0, "impulse");
    for (int k = 0; k < 8; k++) exp_q.push_back(pk(32'h1000, 0));
    drain_exact(8, "impulse");
    end_x(0);

    // DC -> energy in bin 0
    for (int i = 0; i < 8; i++) vin[i] = pk(32'h0100, 0);
    run(0, 1'b0, "dc");
    exp_q.push_back(pk(32'h0800, 0));
    for (int k = 1; k < 8; k++) exp_q.push_back(32'h0);
    drain_exact(8, "dc");
    end_x(0);

    // Alternating sign -> energy in bin N/2
    for (int i = 0; i < 8; i++) vin[i] = pk((i % 2 == 0) ? 32'h0100 : -32'sh0100, 0);
    run(0, 1'b0, "alt");
    for (int k = 0; k < 8; k++) exp_q.push_back((k == 4) ? pk(32'h0800, 0) : 32'h0);
    drain_exact(8, "alt");
    end_x(0);

    // Scaled inverse of a single bin -> flat output at 1/N
    clear_vin();
    vin[0] = pk(32'h0800, 0);
    run(1, 1'b1, "inv");
    for (int k = 0; k < 8; k++) exp_q.push_back(pk(32'h0100, 0));
    drain_exact(8, "inv");
    end_x(1);

    // Random forward vs DFT, then scaled inverse must return the input
    for (int it = 0; it < 2; it++) begin
      rand_vin(8, 768);
      for (int i = 0; i < 8; i++) orig[i] = vin[i];
      dft(8, 1'b0);
      run(0, 1'b0, "rfwd");
      cmp_ref(8, 3, $sformatf("rfwd%0d", it));
      end_x(0);
      for (int i = 0; i < 8; i++) vin[i] = vout[i];
      run(1, 1'b1, "rinv");
      for (int k = 0; k < 8; k++) begin
        chk_tol($sformatf("roundtrip%0d re%0d", it, k), re_of(vout[k]), real'(re_of(orig[k])), 3);
        chk_tol($sformatf("roundtrip%0d im%0d", it, k), im_of(vout[k]), real'(im_of(orig[k])), 3);
      end
      end_x(1);
    end

    // 16-point shifted impulse -> rotating phasor
    clear_vin();
    vin[1] = pk(32'h1000, 0);
    dft(16, 1'b0);
    run(2, 1'b0, "n16imp");
    cmp_ref(16, 2, "n16imp");
    chk("n16imp bin4 exact", vout[4], pk(0, -32'sh1000));
    end_x(2);

    // 16-point random vs DFT
    rand_vin(16, 512);
    dft(16, 1'b0);
    run(2, 1'b0, "n16rnd");
    cmp_ref(16, 6, "n16rnd");
    end_x(2);

    // Abort mid-CALC: busy drops next edge, ack never rises
    rand_vin(8, 256);
    load(0, 1'b0);
    repeat (5) tick();
    chk("abort busy in calc", {31'b0, busy_a[0]}, 32'd1);
    sel_a[0] = 1'b0;
    tick();
    chk("abort busy", {31'b0, busy_a[0]}, 32'd0);
    chk("abort state", {29'b0, st_a[0]}, {29'b0, ST_IDLE});
    ack_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack_a[0] !== 1'b0 || dout_a[0] !== 32'h0) ack_seen++;
    end
    chk("abort no ack", ack_seen, 0);

    // Reset during OUT
    rand_vin(8, 256);
    load(0, 1'b0);
    wait_ack(0, lat);
    chk("rstout first ack latency", lat, 20);
    tick();
    rst = 1'b1;
    tick();
    chk("rstout ack", {31'b0, ack_a[0]}, 32'd0);
    chk("rstout dout", dout_a[0], 32'd0);
    chk("rstout busy", {31'b0, busy_a[0]}, 32'd0);
    rst = 1'b0;
    sel_a[0] = 1'b0;
    tick();

    // Hold sel after the last bin: stays in DONE, then fresh transaction
    rand_vin(8, 256);
    run(0, 1'b0, "hold");
    din_a[0] = $urandom;
    repeat (4) tick();
    chk("hold state done", {29'b0, st_a[0]}, {29'b0, ST_DONE});
    chk("hold ack", {31'b0, ack_a[0]}, 32'd0);
    chk("hold dout", dout_a[0], 32'd0);
    chk("hold busy", {31'b0, busy_a[0]}, 32'd0);
    end_x(0);
    clear_vin();
    vin[0] = pk(32'h1000, 0);
    run(0, 1'b0, "fresh");
    for (int k = 0; k < 8; k++) exp_q.push_back(pk(32'h1000, 0));
    drain_exact(8, "fresh");
    end_x(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
